// File: rtl/fq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fq_pkg;

    localparam int          INSN_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DISCARD
    } state_t;

    typedef struct packed {
        logic [INSN_W-1:0] pc;
        logic [INSN_W-1:0] ins;
    } entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: redirect input, instruction memory handshake and decode handshake.
interface fetch_queue_if;
    import fq_pkg::*;

    logic              redirect;
    logic [INSN_W-1:0] redirect_pc;
    logic              imem_req;
    logic [INSN_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INSN_W-1:0] imem_rdata;
    logic              ins_valid;
    logic [INSN_W-1:0] ins;
    logic [INSN_W-1:0] ins_pc;
    logic              ins_ready;

    modport master (
        input  redirect, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output ins_valid, ins, ins_pc,
        input  ins_ready
    );

    modport slave (
        output redirect, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  ins_valid, ins, ins_pc,
        output ins_ready
    );

endinterface

// File: rtl/fq_fifo.sv
// DEPTH-entry circular buffer of {pc, ins} with synchronous flush.
module fq_fifo
    import fq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    assign head = mem[rd_ptr];

    // Pointer/count update; flush wins over push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: one outstanding imem request, DEPTH-entry queue to decode,
// redirect flushes and refetches. Define FQ_BYPASS_EN to pass a response straight
// to decode when the queue is empty and decode is ready.
module fetch_queue
    import fq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    fetch_queue_if.master      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t       state, state_nxt;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_pc;
    logic         req_q;
    logic [AW:0]  count;
    logic [AW:0]  fill_nxt;
    entry_t       head;
    logic         grant, rsp, push, pop, bypass, nonempty;

    assign grant    = req_q & bus.imem_gnt;
    assign rsp      = (state == S_WAIT) & bus.imem_rvalid;
    assign nonempty = (count != '0);

`ifdef FQ_BYPASS_EN
    assign bypass = rsp & ~bus.redirect & ~nonempty & bus.ins_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = rsp & ~bus.redirect & ~bypass;
    assign pop  = nonempty & bus.ins_ready & ~bus.redirect;

    fq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (push),
        .push_data ('{pc: req_pc, ins: bus.imem_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = fetch_pc;
    assign bus.ins_valid = nonempty | bypass;
    assign bus.ins       = bypass ? bus.imem_rdata : head.ins;
    assign bus.ins_pc    = bypass ? req_pc         : head.pc;

    // Queue occupancy after this edge; lets imem_req be a registered output.
    always_comb begin
        fill_nxt = count;
        if (bus.redirect)     fill_nxt = '0;
        else if (push & ~pop) fill_nxt = count + 1'b1;
        else if (pop & ~push) fill_nxt = count - 1'b1;
    end

    // Next FSM state; redirect turns a live or just-granted request into a discard.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:   if (grant) state_nxt = bus.redirect ? S_DISCARD : S_WAIT;
            S_WAIT:    if (bus.imem_rvalid) state_nxt = S_FETCH;
                       else if (bus.redirect) state_nxt = S_DISCARD;
            S_DISCARD: if (bus.imem_rvalid) state_nxt = S_FETCH;
            default:   state_nxt = S_FETCH;
        endcase
    end

    // FSM, fetch PC and registered request line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            req_q    <= 1'b0;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state <= state_nxt;
            req_q <= (state_nxt == S_FETCH) && (fill_nxt < FULL);
            if (grant) req_pc <= fetch_pc;
            if (bus.redirect) fetch_pc <= word_align(bus.redirect_pc);
            else if (grant)   fetch_pc <= fetch_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table, directed corner sequences and random traffic
// against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
`ifdef FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if bus();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: fetched words waiting for decode, next fetch address,
    // whether a request is outstanding and whether its answer is unwanted.
    logic [63:0] q[$];
    logic [31:0] m_fpc, m_rpc;
    bit          m_out, m_disc, m_reqok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic mreset();
        q.delete();
        m_fpc = 32'h3000; m_rpc = 32'h3000;
        m_out = 0; m_disc = 0; m_reqok = 0;
    endtask

    function automatic bit m_bypass();
        return BYP && m_out && !m_disc && bus.imem_rvalid && q.size() == 0
               && bus.ins_ready && !bus.redirect;
    endfunction

    task automatic mcheck();
        bit ev;
        logic [63:0] e;
        chk("req", 32'(bus.imem_req), 32'(m_reqok));
        if (m_reqok) chk("addr", bus.imem_addr, m_fpc);
        ev = (q.size() > 0) || m_bypass();
        chk("valid", 32'(bus.ins_valid), 32'(ev));
        if (ev) begin
            e = m_bypass() ? {m_rpc, bus.imem_rdata} : q[0];
            chk("ins_pc", bus.ins_pc, e[63:32]);
            chk("ins", bus.ins, e[31:0]);
        end
        chk("count", 32'(dut.count), 32'(q.size()));
    endtask

    task automatic mupdate();
        bit grant, bp;
        if (!reset) begin mreset(); return; end
        grant = m_reqok && bus.imem_gnt;
        bp = m_bypass();
        if (bus.redirect) begin
            q.delete();
            if (grant) begin m_out = 1; m_disc = 1; end
            else if (m_out && bus.imem_rvalid) begin m_out = 0; m_disc = 0; end
            else if (m_out) m_disc = 1;
            m_fpc = bus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (q.size() > 0 && bus.ins_ready) void'(q.pop_front());
            if (m_out && bus.imem_rvalid) begin
                if (!m_disc && !bp) q.push_back({m_rpc, bus.imem_rdata});
                m_out = 0; m_disc = 0;
            end
            if (grant) begin
                m_out = 1; m_disc = 0; m_rpc = m_fpc; m_fpc = m_fpc + 32'd4;
            end
        end
        m_reqok = !m_out && q.size() < DEPTH;
    endtask

    task automatic drv(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] rpc);
        bus.imem_gnt = g; bus.imem_rvalid = rv; bus.imem_rdata = rd;
        bus.ins_ready = rdy; bus.redirect = rdr; bus.redirect_pc = rpc;
    endtask

    task automatic tick(); @(negedge clk); mcheck(); endtask
    task automatic tock(); @(posedge clk); mupdate(); #1; endtask
    task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic rdr, input logic [31:0] rpc);
        drv(g, rv, rd, rdy, rdr, rpc); tick(); tock();
    endtask

    task automatic do_reset();
        drv(0, 0, 0, 0, 0, 0);
        reset = 1'b0; mreset();
        repeat (2) begin tick(); tock(); end
        reset = 1'b1;
    endtask

    typedef struct {
        logic gnt, rv; logic [31:0] rd; logic rdy;
        logic e_req; logic [31:0] e_addr; logic e_v; logic [31:0] e_pc, e_ins; int e_cnt;
    } vec_t;
    vec_t tbl[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Fill to DEPTH with decode stalled, pop once, refill.
        tbl[0]  = '{1,0,32'h0,        0, 0,32'h0,   0,32'h0,   32'h0,        0};
        tbl[1]  = '{1,0,32'h0,        0, 1,32'h3000,0,32'h0,   32'h0,        0};
        tbl[2]  = '{1,1,32'hA000_3000,0, 0,32'h0,   0,32'h0,   32'h0,        0};
        tbl[3]  = '{1,0,32'h0,        0, 1,32'h3004,1,32'h3000,32'hA000_3000,1};
        tbl[4]  = '{1,1,32'hA000_3004,0, 0,32'h0,   1,32'h3000,32'hA000_3000,1};
        tbl[5]  = '{1,0,32'h0,        0, 1,32'h3008,1,32'h3000,32'hA000_3000,2};
        tbl[6]  = '{1,1,32'hA000_3008,0, 0,32'h0,   1,32'h3000,32'hA000_3000,2};
        tbl[7]  = '{1,0,32'h0,        0, 1,32'h300C,1,32'h3000,32'hA000_3000,3};
        tbl[8]  = '{1,1,32'hA000_300C,0, 0,32'h0,   1,32'h3000,32'hA000_3000,3};
        tbl[9]  = '{1,0,32'h0,        0, 0,32'h0,   1,32'h3000,32'hA000_3000,4};
        tbl[10] = '{1,0,32'h0,        1, 0,32'h0,   1,32'h3000,32'hA000_3000,4};
        tbl[11] = '{1,0,32'h0,        0, 1,32'h3010,1,32'h3004,32'hA000_3004,3};
        tbl[12] = '{1,0,32'h0,        0, 0,32'h0,   1,32'h3004,32'hA000_3004,3};

        do_reset();
        chk("rst_addr", bus.imem_addr, 32'h3000);
        chk("rst_ins", bus.ins, 32'h0);
        chk("rst_pc", bus.ins_pc, 32'h0);
        for (int i = 0; i < 13; i++) begin
            drv(tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].rdy, 0, 0);
            tick();
            chk("t_req", 32'(bus.imem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk("t_addr", bus.imem_addr, tbl[i].e_addr);
            chk("t_valid", 32'(bus.ins_valid), 32'(tbl[i].e_v));
            if (tbl[i].e_v) begin
                chk("t_pc", bus.ins_pc, tbl[i].e_pc);
                chk("t_ins", bus.ins, tbl[i].e_ins);
            end
            chk("t_cnt", 32'(dut.count), 32'(tbl[i].e_cnt));
            tock();
        end

        // Redirect while waiting; the late response must be dropped.
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h3040);
        cyc(0, 0, 0, 0, 0, 0);
        drv(0, 1, 32'hDEAD, 1, 0, 0); tick();
        chk("rw_valid", 32'(bus.ins_valid), 32'h0); tock();
        drv(0, 0, 0, 1, 0, 0); tick();
        chk("rw_req", 32'(bus.imem_req), 32'h1);
        chk("rw_addr", bus.imem_addr, 32'h3040);
        chk("rw_cnt", 32'(dut.count), 32'h0); tock();

        // Redirect coinciding with rvalid and a ready decode, two words queued.
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h1111, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h2222, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        drv(0, 1, 32'h3333, 1, 1, 32'h3100); tick();
        chk("rr_cnt_before", 32'(dut.count), 32'h2); tock();
        drv(0, 0, 0, 1, 0, 0); tick();
        chk("rr_cnt", 32'(dut.count), 32'h0);
        chk("rr_valid", 32'(bus.ins_valid), 32'h0);
        chk("rr_addr", bus.imem_addr, 32'h3100); tock();

        // Misaligned redirect to the top of the address space, then wrap.
        do_reset();
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        drv(1, 0, 0, 0, 0, 0); tick();
        chk("wr_addr0", bus.imem_addr, 32'hFFFF_FFFC); tock();
        cyc(0, 1, 32'h5555, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0); tick();
        chk("wr_req1", 32'(bus.imem_req), 32'h1);
        chk("wr_addr1", bus.imem_addr, 32'h0);
        chk("wr_pc", bus.ins_pc, 32'hFFFF_FFFC); tock();

        // Reset while waiting; the stale response must not reach decode.
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        reset = 1'b0; mreset(); #1;
        chk("rs_req", 32'(bus.imem_req), 32'h0);
        chk("rs_addr", bus.imem_addr, 32'h3000);
        drv(0, 0, 0, 0, 0, 0); tick(); tock();
        reset = 1'b1;
        drv(0, 1, 32'hBEEF, 1, 0, 0); tick();
        chk("rs_valid", 32'(bus.ins_valid), 32'h0); tock();
        drv(0, 0, 0, 1, 0, 0); tick();
        chk("rs_req1", 32'(bus.imem_req), 32'h1);
        chk("rs_addr1", bus.imem_addr, 32'h3000); tock();

        // Response into an empty queue with decode ready.
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        drv(0, 1, 32'h1234_5678, 1, 0, 0); tick();
        if (BYP) begin
            chk("bp_valid", 32'(bus.ins_valid), 32'h1);
            chk("bp_ins", bus.ins, 32'h1234_5678);
            chk("bp_pc", bus.ins_pc, 32'h3000);
        end else begin
            chk("bp_valid", 32'(bus.ins_valid), 32'h0);
        end
        tock();
        drv(0, 0, 0, 1, 0, 0); tick();
        chk("bp_valid1", 32'(bus.ins_valid), BYP ? 32'h0 : 32'h1); tock();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic rv, rdr;
            rv  = m_out && ($urandom_range(0, 2) != 0);
            rdr = ($urandom_range(0, 15) == 0);
            cyc(1'($urandom_range(0, 1)), rv, $urandom(), 1'($urandom_range(0, 1)),
                rdr, (i % 50 == 7) ? 32'hFFFF_FFF8 : $urandom());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
